// File: rtl/control_unit_stack.sv
// Control unit for the accumulator datapath: FSM, PC, instruction register,
// address mux and a return-address stack for CALL/RET.
module control_unit_stack #(
  parameter  int DATA_W      = 16,
  parameter  int ADR_W       = 6,
  parameter  int STACK_DEPTH = 4,
  localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              carry,
  input  logic              boot,
  input  logic [DATA_W-1:0] data_in,
  output logic [ADR_W-1:0]  adr,
  output logic              enable_mem,
  output logic              w_mem,
  output logic              load_R1,
  output logic              load_accu,
  output logic              load_carry,
  output logic              clear_carry,
  output logic [2:0]        sel_UAL,
  output logic              stack_err,
  output logic [SP_W-1:0]   sp
);

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_LOADR1, S_ALU
  } state_e;

  typedef enum logic [2:0] {
    OP_NOR = 3'b000, OP_ADD = 3'b001, OP_STA = 3'b010, OP_JCC = 3'b011,
    OP_LDA = 3'b100, OP_JMP = 3'b101, OP_CALL = 3'b110, OP_RET = 3'b111
  } op_e;

  state_e           r_state;
  state_e           w_next_state;
  logic [ADR_W-1:0] r_pc;
  op_e              r_ri_op;
  logic [ADR_W-1:0] r_ri_opd;
  logic [SP_W-1:0]  r_sp;
  logic             r_stack_err;
  // Sized to the full index range so sp selects an entry without width games.
  logic [ADR_W-1:0] r_stack [2**SP_W];

  op_e              w_op;
  logic [ADR_W-1:0] w_operand;
  logic             w_unused_bits;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic [SP_W-1:0]  w_sp_dec;

  logic [ADR_W-1:0] w_adr;
  logic             w_en_mem;
  logic             w_wr_mem;
  logic             w_ld_r1;
  logic             w_ld_accu;
  logic             w_ld_carry;
  logic             w_clr_carry;
  logic [2:0]       w_sel;

  assign w_op          = op_e'(data_in[DATA_W-1 -: 3]);
  assign w_operand     = data_in[ADR_W-1:0];
  assign w_unused_bits = ^data_in;
  assign w_full        = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty       = (r_sp == '0);
  assign w_sp_dec      = r_sp - SP_W'(1);
  assign w_push        = ce && !boot && (r_state == S_EXEC) &&
                         (r_ri_op == OP_CALL) && !w_full;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch can be inferred.
  always_comb begin
    w_next_state = r_state;
    w_adr        = r_pc;
    w_en_mem     = 1'b0;
    w_wr_mem     = 1'b0;
    w_ld_r1      = 1'b0;
    w_ld_accu    = 1'b0;
    w_ld_carry   = 1'b0;
    w_clr_carry  = 1'b0;
    w_sel        = 3'b000;
    unique case (r_state)
      S_BOOT:   if (!boot) w_next_state = S_FETCH;
      S_FETCH: begin
        w_en_mem     = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC: begin
        w_adr        = r_ri_opd;
        w_next_state = S_FETCH;
        case (r_ri_op)
          OP_NOR, OP_ADD, OP_LDA: begin
            w_en_mem     = 1'b1;
            w_next_state = S_LOADR1;
          end
          OP_STA: begin
            w_en_mem = 1'b1;
            w_wr_mem = 1'b1;
          end
          OP_JCC:  w_clr_carry = carry;
          default: ;
        endcase
      end
      S_LOADR1: begin
        w_adr        = r_ri_opd;
        w_ld_r1      = 1'b1;
        w_next_state = S_ALU;
      end
      S_ALU: begin
        w_adr        = r_ri_opd;
        w_ld_accu    = 1'b1;
        w_ld_carry   = (r_ri_op == OP_ADD);
        w_sel        = r_ri_op;
        w_next_state = S_FETCH;
      end
      default: w_next_state = S_BOOT;
    endcase
    if (boot) w_next_state = S_BOOT;
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    r_state <= S_BOOT;
    else if (ce) r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc        <= '0;
      r_ri_op     <= OP_NOR;
      r_ri_opd    <= '0;
      r_sp        <= '0;
      r_stack_err <= 1'b0;
    end else if (ce) begin
      if (boot || r_state == S_BOOT) begin
        r_pc <= '0;
      end else begin
        case (r_state)
          S_DECODE: begin
            r_ri_op  <= w_op;
            r_ri_opd <= w_operand;
            r_pc     <= r_pc + ADR_W'(1);
          end
          S_EXEC: begin
            case (r_ri_op)
              OP_JCC: if (!carry) r_pc <= r_ri_opd;
              OP_JMP: r_pc <= r_ri_opd;
              OP_CALL: begin
                r_pc <= r_ri_opd;
                if (w_full) r_stack_err <= 1'b1;
                else        r_sp        <= r_sp + SP_W'(1);
              end
              OP_RET: begin
                if (w_empty) begin
                  r_stack_err <= 1'b1;
                end else begin
                  r_pc <= r_stack[w_sp_dec];
                  r_sp <= w_sp_dec;
                end
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: stack storage has no reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp] <= r_pc;
  end

  assign adr         = w_adr;
  assign sel_UAL     = w_sel;
  assign enable_mem  = w_en_mem    & ce;
  assign w_mem       = w_wr_mem    & ce;
  assign load_R1     = w_ld_r1     & ce;
  assign load_accu   = w_ld_accu   & ce;
  assign load_carry  = w_ld_carry  & ce;
  assign clear_carry = w_clr_carry & ce;
  assign stack_err   = r_stack_err;
  assign sp          = r_sp;

endmodule

// File: tb/tb_control_unit_stack.sv
// Scoreboard bench for control_unit_stack: an instruction-level model predicts
// every strobe event (with its active-cycle timestamp); a monitor compares.
module tb_control_unit_stack;
  localparam int DATA_W = 16;
  localparam int ADR_W  = 6;
  localparam int DEPTH  = 4;
  localparam int SP_W   = $clog2(DEPTH + 1);
  localparam int PAT_N  = 4096;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ce = 1'b1;
  logic              carry = 1'b0;
  logic              boot = 1'b1;
  logic [DATA_W-1:0] data_in = '0;
  logic [ADR_W-1:0]  adr;
  logic              enable_mem, w_mem, load_R1, load_accu, load_carry, clear_carry;
  logic [2:0]        sel_UAL;
  logic              stack_err;
  logic [SP_W-1:0]   sp;

  control_unit_stack #(.DATA_W(DATA_W), .ADR_W(ADR_W), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ce(ce), .carry(carry), .boot(boot), .data_in(data_in),
    .adr(adr), .enable_mem(enable_mem), .w_mem(w_mem), .load_R1(load_R1),
    .load_accu(load_accu), .load_carry(load_carry), .clear_carry(clear_carry),
    .sel_UAL(sel_UAL), .stack_err(stack_err), .sp(sp)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int       t;
    bit       en, w, r1, accu, lc, clr;
    bit [2:0] sel;
    int       sp;
    bit       err;
    bit [5:0] adr;
  } ev_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] mem [64];
  bit          carry_pat [PAT_N];
  int          ac = 0;
  bit          ac_run = 1'b0;
  bit          ce_rand = 1'b0;
  int          stall_at = -1;
  int          stall_cnt = 0;
  ev_t         exp_q [$];
  int          m_stack [$];
  bit          m_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_ev(input ev_t e);
    logic [15:0] t16;
    logic [3:0]  sp4;
    t16 = 16'(e.t);
    sp4 = 4'(e.sp);
    return {28'd0, t16, e.en, e.w, e.r1, e.accu, e.lc, e.clr, e.sel, sp4, e.err, e.adr};
  endfunction

  function automatic void push_ev(input int t, input bit en, input bit w, input bit r1,
                                  input bit accu, input bit lc, input bit clr,
                                  input bit [2:0] sel, input int a);
    ev_t e;
    e.t = t; e.en = en; e.w = w; e.r1 = r1; e.accu = accu; e.lc = lc; e.clr = clr;
    e.sel = sel; e.sp = m_stack.size(); e.err = m_err;
    e.adr = en ? 6'(a) : 6'd0;
    exp_q.push_back(e);
  endfunction

  // Instruction-level model: walks the program n instructions, then the next fetch.
  task automatic build_expected(input int n);
    int          pc, t, op, opd;
    logic [15:0] ins;
    pc = 0;
    t  = 0;
    for (int k = 0; k <= n; k++) begin
      push_ev(t, 1, 0, 0, 0, 0, 0, 3'd0, pc);
      if (k == n) break;
      ins = mem[pc];
      op  = int'(ins[15:13]);
      opd = int'(ins[5:0]);
      pc  = (pc + 1) % 64;
      case (op)
        0, 1, 4: begin
          push_ev(t + 2, 1, 0, 0, 0, 0, 0, 3'd0, opd);
          push_ev(t + 3, 0, 0, 1, 0, 0, 0, 3'd0, 0);
          push_ev(t + 4, 0, 0, 0, 1, op == 1, 0, 3'(op), 0);
          t += 5;
        end
        2: begin
          push_ev(t + 2, 1, 1, 0, 0, 0, 0, 3'd0, opd);
          t += 3;
        end
        3: begin
          if (carry_pat[t + 2]) push_ev(t + 2, 0, 0, 0, 0, 0, 1, 3'd0, 0);
          else                  pc = opd;
          t += 3;
        end
        5: begin
          pc = opd;
          t += 3;
        end
        6: begin
          if (m_stack.size() == DEPTH) m_err = 1'b1;
          else                         m_stack.push_back(pc);
          pc = opd;
          t += 3;
        end
        default: begin
          if (m_stack.size() == 0) m_err = 1'b1;
          else                     pc = m_stack.pop_back();
          t += 3;
        end
      endcase
    end
  endtask

  // Per-cycle driver: counts active cycles, drives ce and carry away from the edge.
  initial forever begin
    @(posedge clk);
    if (ac_run && ce) ac++;
    #1;
    if (ac_run) begin
      if (ac == stall_at && stall_cnt > 0) begin
        ce = 1'b0;
        stall_cnt--;
      end else begin
        ce = (ce_rand && $urandom_range(3) == 0) ? 1'b0 : 1'b1;
      end
      carry = carry_pat[ac % PAT_N];
    end
  end

  // Memory: read data appears the cycle after an enable_mem read.
  initial forever begin
    logic       rd;
    logic [5:0] ra;
    @(negedge clk);
    rd = enable_mem && !w_mem;
    ra = adr;
    @(posedge clk);
    #1;
    if (rd) data_in = mem[ra];
  end

  // Monitor: every strobe cycle outside reset/boot is one scoreboard event.
  initial forever begin
    ev_t got;
    ev_t e;
    @(negedge clk);
    if (rst && !boot &&
        (enable_mem || w_mem || load_R1 || load_accu || load_carry || clear_carry)) begin
      got.t = ac; got.en = enable_mem; got.w = w_mem; got.r1 = load_R1;
      got.accu = load_accu; got.lc = load_carry; got.clr = clear_carry;
      got.sel = sel_UAL; got.sp = int'(sp); got.err = stack_err;
      got.adr = enable_mem ? adr : 6'd0;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: actual=%h required=none", pack_ev(got));
      end else begin
        e = exp_q.pop_front();
        check($sformatf("event_t%0d", e.t), pack_ev(got), pack_ev(e));
      end
    end
  end

  task automatic run_prog(input string name, input int n, input bit do_reset, input bit rand_ce);
    int budget;
    ac_run  = 1'b0;
    ce_rand = 1'b0;
    ce      = 1'b1;
    boot    = 1'b1;
    @(negedge clk);
    if (do_reset) begin
      rst = 1'b0;
      m_stack.delete();
      m_err = 1'b0;
      #1;
      check({name, "_reset"}, {adr, enable_mem, w_mem, load_R1, load_accu, load_carry,
                               clear_carry, sel_UAL, sp, stack_err}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
    end
    repeat (3) begin
      @(negedge clk);
      check({name, "_boot_idle"}, {adr, enable_mem, w_mem, load_R1, load_accu,
                                   load_carry, clear_carry}, 64'd0);
      check({name, "_boot_stack"}, {sp, stack_err}, {3'(m_stack.size()), m_err});
    end
    ac = 0;
    build_expected(n);
    boot    = 1'b0;
    ce_rand = rand_ce;
    @(posedge clk);
    #2 ac_run = 1'b1;
    budget = 30 * n + 60;
    for (int c = 0; c < budget && exp_q.size() > 0; c++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: actual=%0d events outstanding required=0", name, exp_q.size());
      exp_q.delete();
    end
    ac_run    = 1'b0;
    boot      = 1'b1;
    stall_at  = -1;
    stall_cnt = 0;
    @(posedge clk);
    #1 ce = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    for (int i = 0; i < PAT_N; i++) carry_pat[i] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_all();
    mem[0] = 16'h2020; mem[6'h20] = 16'd5;
    run_prog("alu_add", 1, 1, 0);

    clear_all();
    mem[0] = 16'h6010; mem[1] = 16'h6010;
    carry_pat[2] = 1'b1;
    run_prog("jcc", 2, 1, 0);

    clear_all();
    mem[0] = 16'hA004; mem[4] = 16'hC030; mem[6'h30] = 16'hE000;
    run_prog("call_ret", 3, 1, 0);

    clear_all();
    mem[0] = 16'hC001; mem[1] = 16'hC002; mem[2] = 16'hC003;
    mem[3] = 16'hC004; mem[4] = 16'hC020;
    run_prog("overflow", 5, 1, 0);
    mem[0] = 16'hE000;
    run_prog("boot_keeps_stack", 1, 0, 0);

    clear_all();
    mem[0] = 16'hE000;
    run_prog("underflow", 1, 1, 0);

    clear_all();
    mem[0] = 16'h8020; mem[6'h20] = 16'h1234;
    stall_at  = 3;
    stall_cnt = 4;
    run_prog("ce_stall", 1, 1, 0);

    clear_all();
    mem[0] = 16'hA03F; mem[6'h3F] = 16'h4010;
    run_prog("pc_wrap", 2, 1, 0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
      for (int i = 0; i < PAT_N; i++) carry_pat[i] = 1'($urandom_range(1));
      run_prog($sformatf("random%0d", r), 50, 1, r[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit_stack.md
Name: control_unit_stack

Overview:
- Parametrised next-generation control unit for the accumulator datapath: FSM, program counter, instruction register and address mux in one block.
- Opcode field widened to 3 bits, adding LDA, JMP, CALL and RET. An internal return-address stack of configurable depth supports subroutines.
- Drives the memory address and datapath strobes (R1, accumulator, carry, ALU select) exactly as the current datapath expects.

Parameters:
- DATA_W, 16: instruction and memory word width; must be ≥ ADR_W+3.
- ADR_W, 6: memory address width; sizes PC, RI operand and stack entries.
- STACK_DEPTH, 4: number of return-address entries; must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; all state updates only when ce=1.
- carry  in  1  carry flag from datapath.
- boot  in  1  1 = hold in BOOT state (memory being loaded externally).
- data_in  in  DATA_W  memory read data; valid the cycle after an enable_mem read.
- adr  out  ADR_W  memory address.
- enable_mem  out  1  memory access strobe.
- w_mem  out  1  memory write strobe (valid with enable_mem).
- load_R1  out  1  datapath R1 load.
- load_accu  out  1  accumulator load.
- load_carry  out  1  carry register load.
- clear_carry  out  1  carry register clear.
- sel_UAL  out  3  ALU operation select.
- stack_err  out  1  sticky overflow/underflow flag.
- sp  out  clog2(STACK_DEPTH+1)  stack occupancy, debug.

Behaviour:
- Instruction decode:
  - op = data_in[DATA_W-1 -: 3]; operand = data_in[ADR_W-1:0]; remaining bits ignored.
  - Encodings: 000 NOR, 001 ADD, 010 STA, 011 JCC, 100 LDA, 101 JMP, 110 CALL, 111 RET.
- Reset (rst=0, async):
  - State BOOT; PC=0; RI=0; sp=0; stack_err=0.
  - All strobes 0, sel_UAL=000, adr=0.
- ce gating:
  - ce=0 freezes all registers.
  - All strobe outputs are AND-ed with ce; adr and sel_UAL hold.
- States: BOOT, FETCH, DECODE, EXEC, LOADR1, ALU.
  - BOOT: PC held at 0, no strobes. Leave to FETCH when boot=0. boot=1 in any state forces BOOT next cycle and clears PC; stack and stack_err are untouched.
  - FETCH: adr=PC, enable_mem=1. Next: DECODE.
  - DECODE: load RI from data_in; PC<=PC+1, wrapping modulo 2^ADR_W. Next: EXEC.
  - EXEC: adr=RI operand; action by op (next list).
- EXEC action by op:
  - NOR/ADD/LDA: enable_mem=1 (operand read). Next: LOADR1.
  - STA: enable_mem=1, w_mem=1. Next: FETCH.
  - JCC:
    - carry=1: clear_carry=1, PC unchanged.
    - carry=0: PC<=operand.
    - Next: FETCH.
  - JMP: PC<=operand. Next: FETCH.
  - CALL:
    - Not full: push PC (already incremented), sp+1, PC<=operand.
    - Full (sp=STACK_DEPTH): stack_err<=1, no push, PC<=operand (degrades to JMP).
    - Next: FETCH.
  - RET:
    - sp>0: PC<=top entry, sp-1.
    - sp=0: stack_err<=1, PC unchanged (NOP).
    - Next: FETCH.
- LOADR1: load_R1=1 (captures operand data). Next: ALU.
- ALU:
  - load_accu=1, sel_UAL = RI op.
  - load_carry=1 only for ADD.
  - Next: FETCH.
- sel_UAL=000 in all other states; it is only meaningful with load_accu.
- Instruction cycle counts (ce always 1): ALU ops 5; STA/JCC/JMP/CALL/RET 3.
- stack_err is cleared only by reset.
- Stack is LIFO, storage indexed by sp. Entries are not cleared on pop.
- boot asserted mid-instruction aborts it: no partial stack or PC update beyond that cycle.

Test Plan:
- Reset/boot:
  - Stimulus: rst=0, then rst=1 with boot=1 for 3 cycles, then boot=0.
  - Required: adr=0 and all strobes 0 throughout boot; first FETCH has adr=0 and enable_mem=1 exactly one cycle after boot falls.
- ALU sequence:
  - Stimulus: mem[0]=ADD 0x20 (16'h2020); mem[0x20]=5.
  - Required: strobes in order enable_mem(adr=0), load RI, enable_mem(adr=0x20), load_R1, then load_accu+load_carry with sel_UAL=001; next FETCH at adr=1.
- JCC:
  - Stimulus: JCC 0x10 with carry=1, then the same instruction with carry=0.
  - Required: first gives clear_carry pulse and next fetch at PC+1; second gives next fetch adr=0x10.
- CALL/RET:
  - Stimulus: CALL 0x30 at address 4; RET at 0x30.
  - Required: sp 0→1→0; fetch after RET at adr=5.
- Stack boundaries (STACK_DEPTH=4):
  - Stimulus: 5 nested CALLs.
  - Required: fifth sets stack_err=1 and still jumps; sp stays 4.
  - Stimulus (after reset): RET with sp=0.
  - Required: stack_err=1, next fetch at PC+1.
- ce stall and PC wrap:
  - Stimulus: ce=0 for 4 cycles mid-LOADR1.
  - Required: no strobes, state resumes unchanged.
  - Stimulus: JMP 0x3F followed by a STA at 0x3F.
  - Required: next fetch at adr=0x00.
